// File: rtl/myrisc16_mem_arb.sv
// myrisc16_mem_arb: two-port round-robin arbiter in front of the single
// synchronous 16-bit-word memory. Port 0 is the core, port 1 the loader/debug.
// One access per cycle, grant is combinational, read data returns one cycle
// after the grant. Defining MYRISC16_ARB_LOCK_EN adds mN_lock_i and bounded
// locked sequences (at most LOCK_MAX consecutive locked grants while the
// other master waits); without it the arbiter is pure round-robin.
module myrisc16_mem_arb #(
    parameter int AW       = 16,
    parameter int DW       = 16,
    parameter int LOCK_MAX = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          m0_req_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_addr_i,
    input  logic [DW-1:0] m0_wdata_i,
`ifdef MYRISC16_ARB_LOCK_EN
    input  logic          m0_lock_i,
`endif
    output logic          m0_gnt_o,
    output logic          m0_rvalid_o,
    output logic [DW-1:0] m0_rdata_o,
    input  logic          m1_req_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic [DW-1:0] m1_wdata_i,
`ifdef MYRISC16_ARB_LOCK_EN
    input  logic          m1_lock_i,
`endif
    output logic          m1_gnt_o,
    output logic          m1_rvalid_o,
    output logic [DW-1:0] m1_rdata_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i
);

    // LOCK_MAX must fit the 8-bit lock counter and allow at least one grant.
    if (LOCK_MAX < 1 || LOCK_MAX > 255) begin : g_bad_lock_max
        $error("myrisc16_mem_arb: LOCK_MAX must be in 1..255");
    end

    logic last_q, last_d;
    logic rd_pend_q, rd_pend_d;
    logic rd_id_q, rd_id_d;

    logic win_valid;
    logic win_id;
    logic sel_we;
    logic lock_hold;
    logic lock_break;
    logic lock_owner;

`ifdef MYRISC16_ARB_LOCK_EN
    localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

    logic       locked_q, locked_d;
    logic       owner_q, owner_d;
    logic [7:0] lock_cnt_q, lock_cnt_d;
    logic       own_req, oth_req, at_max, win_lock;

    assign own_req    = owner_q ? m1_req_i : m0_req_i;
    assign oth_req    = owner_q ? m0_req_i : m1_req_i;
    assign at_max     = (lock_cnt_q >= LOCK_MAX_C);
    // Owner keeps the memory unless its quota is used up and the other waits.
    assign lock_hold  = locked_q & own_req & ~(oth_req & at_max);
    assign lock_break = locked_q & own_req & oth_req & at_max;
    assign lock_owner = owner_q;
    assign win_lock   = win_id ? m1_lock_i : m0_lock_i;
`else
    assign lock_hold  = 1'b0;
    assign lock_break = 1'b0;
    assign lock_owner = 1'b0;
`endif

    // Pick the winner: lock first, then round-robin on a tie.
    always_comb begin
        win_valid = rstn & (m0_req_i | m1_req_i);
        if (lock_hold)
            win_id = lock_owner;
        else if (lock_break)
            win_id = ~lock_owner;
        else if (m0_req_i & m1_req_i)
            win_id = ~last_q;
        else
            win_id = m1_req_i;
    end

    assign sel_we      = win_id ? m1_we_i : m0_we_i;
    assign m0_gnt_o    = win_valid & ~win_id;
    assign m1_gnt_o    = win_valid & win_id;
    assign mem_en_o    = win_valid;
    assign mem_we_o    = win_valid & sel_we;
    assign mem_addr_o  = win_id ? m1_addr_i : m0_addr_i;
    assign mem_wdata_o = win_id ? m1_wdata_i : m0_wdata_i;

    assign m0_rvalid_o = rd_pend_q & ~rd_id_q;
    assign m1_rvalid_o = rd_pend_q & rd_id_q;
    assign m0_rdata_o  = mem_rdata_i;
    assign m1_rdata_o  = mem_rdata_i;

    // Next state for round-robin pointer and read-return tracking.
    always_comb begin
        last_d    = last_q;
        rd_id_d   = rd_id_q;
        rd_pend_d = win_valid & ~sel_we;
        if (win_valid) begin
            last_d  = win_id;
            rd_id_d = win_id;
        end
    end

    // Round-robin and read-return registers; reset gives port 0 the first tie.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            last_q    <= 1'b1;
            rd_pend_q <= 1'b0;
            rd_id_q   <= 1'b0;
        end else begin
            last_q    <= last_d;
            rd_pend_q <= rd_pend_d;
            rd_id_q   <= rd_id_d;
        end
    end

`ifdef MYRISC16_ARB_LOCK_EN
    // Lock bookkeeping: the winner's lock request decides; no grant means the
    // owner has let go, so the lock is released.
    always_comb begin
        locked_d   = locked_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        if (win_valid) begin
            if (win_lock) begin
                locked_d = 1'b1;
                owner_d  = win_id;
                if (locked_q && owner_q == win_id)
                    lock_cnt_d = (lock_cnt_q == 8'hFF) ? 8'hFF : lock_cnt_q + 8'd1;
                else
                    lock_cnt_d = 8'd1;
            end else begin
                locked_d   = 1'b0;
                lock_cnt_d = 8'd0;
            end
        end else if (locked_q && !own_req) begin
            locked_d   = 1'b0;
            lock_cnt_d = 8'd0;
        end
    end

    // Lock state registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            locked_q   <= 1'b0;
            owner_q    <= 1'b0;
            lock_cnt_q <= 8'd0;
        end else begin
            locked_q   <= locked_d;
            owner_q    <= owner_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_myrisc16_mem_arb.sv
// Bench for myrisc16_mem_arb: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
// Lock scenarios are exercised when MYRISC16_ARB_LOCK_EN is defined.
module tb_myrisc16_mem_arb;
    localparam int TB_LOCK_MAX = 3;

    logic        clk;
    logic        rstn;
    logic        rq [2];
    logic        we [2];
    logic [15:0] ad [2];
    logic [15:0] wd [2];
    logic        lk [2];
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [15:0] m0_rdata, m1_rdata;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    logic [15:0] mem    [256];
    logic [15:0] shadow [256];

    int tests = 0;
    int fails = 0;

    // model state
    int          m_last, m_lk, m_own, m_cnt, m_pend, m_pid;
    logic [15:0] m_pdata;
    logic        gmask [2];

    myrisc16_mem_arb #(.AW(16), .DW(16), .LOCK_MAX(TB_LOCK_MAX)) dut (
        .clk(clk), .rstn(rstn),
        .m0_req_i(rq[0]), .m0_we_i(we[0]), .m0_addr_i(ad[0]), .m0_wdata_i(wd[0]),
`ifdef MYRISC16_ARB_LOCK_EN
        .m0_lock_i(lk[0]),
`endif
        .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
        .m1_req_i(rq[1]), .m1_we_i(we[1]), .m1_addr_i(ad[1]), .m1_wdata_i(wd[1]),
`ifdef MYRISC16_ARB_LOCK_EN
        .m1_lock_i(lk[1]),
`endif
        .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous memory seen by the DUT
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Predict this cycle's outputs from the arbitration rules, compare, then advance.
    task automatic model_cycle();
        int w;
        w = -1;
        if (rstn) begin
            if (m_lk != 0 && rq[m_own] && !(rq[1-m_own] && m_cnt >= TB_LOCK_MAX)) w = m_own;
            else if (m_lk != 0 && rq[m_own]) w = 1 - m_own;
            else if (rq[0] && rq[1]) w = 1 - m_last;
            else if (rq[0]) w = 0;
            else if (rq[1]) w = 1;
        end
        check("m0_gnt", 16'(m0_gnt), 16'(w == 0));
        check("m1_gnt", 16'(m1_gnt), 16'(w == 1));
        check("mem_en", 16'(mem_en), 16'(w >= 0));
        if (w >= 0) begin
            check("mem_we", 16'(mem_we), 16'(we[w]));
            check("mem_addr", mem_addr, ad[w]);
            if (we[w]) check("mem_wdata", mem_wdata, wd[w]);
        end else begin
            check("mem_we_idle", 16'(mem_we), 16'd0);
        end
        check("m0_rvalid", 16'(m0_rvalid), 16'(m_pend != 0 && m_pid == 0));
        check("m1_rvalid", 16'(m1_rvalid), 16'(m_pend != 0 && m_pid == 1));
        if (m_pend != 0) check("rdata", (m_pid == 0) ? m0_rdata : m1_rdata, m_pdata);

        gmask[0] = (w == 0);
        gmask[1] = (w == 1);
        if (!rstn) begin
            m_last = 1; m_lk = 0; m_cnt = 0; m_pend = 0;
        end else begin
            m_pend = (w >= 0 && !we[w]) ? 1 : 0;
            if (w >= 0) begin
                if (!we[w]) begin
                    m_pid   = w;
                    m_pdata = shadow[ad[w][7:0]];
                end else begin
                    shadow[ad[w][7:0]] = wd[w];
                end
                m_last = w;
`ifdef MYRISC16_ARB_LOCK_EN
                if (lk[w]) begin
                    m_cnt = (m_lk != 0 && m_own == w) ? ((m_cnt < 255) ? m_cnt + 1 : 255) : 1;
                    m_lk  = 1;
                    m_own = w;
                end else begin
                    m_lk = 0; m_cnt = 0;
                end
`endif
            end else if (m_lk != 0 && !rq[m_own]) begin
                m_lk = 0; m_cnt = 0;
            end
        end
    endtask

    task automatic set_req(input int m, input logic r, input logic w, input logic [15:0] a,
                           input logic [15:0] d, input logic l);
        rq[m] = r; we[m] = w; ad[m] = a; wd[m] = d; lk[m] = l;
    endtask

    task automatic new_req(input int m);
        set_req(m, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                16'($urandom_range(0, 31)), 16'($urandom), ($urandom_range(0, 2) != 0));
    endtask

    // advance to the next cycle's drive point
    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        m_last = 1; m_lk = 0; m_cnt = 0; m_pend = 0; m_pid = 0; m_own = 0;
        m_pdata = '0; gmask[0] = 1'b0; gmask[1] = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 16'(i * 16'h0101) ^ 16'hA5A5;
            shadow[i] = 16'(i * 16'h0101) ^ 16'hA5A5;
        end
        mem[16'h40]    = 16'hBEEF;
        shadow[16'h40] = 16'hBEEF;
        mem_rdata = '0;

        // reset with both requesting reads of 0x0001 / 0x0002
        rstn = 1'b0;
        set_req(0, 1'b1, 1'b0, 16'h0001, 16'h0, 1'b0);
        set_req(1, 1'b1, 1'b0, 16'h0002, 16'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); model_cycle();
        end
        check("rst_m0_gnt", 16'(m0_gnt), 16'd0);
        check("rst_m1_gnt", 16'(m1_gnt), 16'd0);
        check("rst_mem_en", 16'(mem_en), 16'd0);
        check("rst_rvalid", 16'({m1_rvalid, m0_rvalid}), 16'd0);
        next_cycle();
        rstn = 1'b1;

        // contention: grants alternate 0,1,0,1 with rvalid one cycle behind
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); model_cycle();
            check("alt_m0_gnt", 16'(m0_gnt), 16'(i % 2 == 0));
            check("alt_m1_gnt", 16'(m1_gnt), 16'(i % 2 == 1));
            if (i == 1) begin
                check("alt_m0_rvalid", 16'(m0_rvalid), 16'd1);
                check("alt_m0_rdata", m0_rdata, 16'hA4A4);
            end
            if (i == 2) begin
                check("alt_m1_rvalid", 16'(m1_rvalid), 16'd1);
                check("alt_m1_rdata", m1_rdata, 16'hA7A7);
            end
            next_cycle();
        end

        // single read by m1 of 0x0040
        set_req(0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        set_req(1, 1'b1, 1'b0, 16'h0040, 16'h0, 1'b0);
        @(negedge clk); model_cycle();
        check("sr_m1_gnt", 16'(m1_gnt), 16'd1);
        next_cycle();
        set_req(1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        @(negedge clk); model_cycle();
        check("sr_m1_rvalid", 16'(m1_rvalid), 16'd1);
        check("sr_m0_rvalid", 16'(m0_rvalid), 16'd0);
        check("sr_m1_rdata", m1_rdata, 16'hBEEF);
        next_cycle();

        // m0 writes 0x1234 to 0x0010, m1 reads it back next cycle
        set_req(0, 1'b1, 1'b1, 16'h0010, 16'h1234, 1'b0);
        @(negedge clk); model_cycle();
        check("wr_m0_gnt", 16'(m0_gnt), 16'd1);
        check("wr_mem_we", 16'(mem_we), 16'd1);
        next_cycle();
        set_req(0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        set_req(1, 1'b1, 1'b0, 16'h0010, 16'h0, 1'b0);
        @(negedge clk); model_cycle();
        check("wr_rd_m1_gnt", 16'(m1_gnt), 16'd1);
        check("wr_no_rvalid", 16'({m1_rvalid, m0_rvalid}), 16'd0);
        next_cycle();
        set_req(1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        @(negedge clk); model_cycle();
        check("wr_rd_m1_rdata", m1_rdata, 16'h1234);
        check("wr_rd_m1_rvalid", 16'(m1_rvalid), 16'd1);
        next_cycle();

`ifdef MYRISC16_ARB_LOCK_EN
        // m1 locked for LOCK_MAX grants, then m0 once, then m1 again
        set_req(1, 1'b1, 1'b0, 16'h0003, 16'h0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); model_cycle();
            check("lk_m1_gnt", 16'(m1_gnt), 16'(i != 3));
            check("lk_m0_gnt", 16'(m0_gnt), 16'(i == 3));
            next_cycle();
            if (i == 0) set_req(0, 1'b1, 1'b0, 16'h0004, 16'h0, 1'b0);
        end
        set_req(0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        set_req(1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        @(negedge clk); model_cycle();
        next_cycle();
`endif

        // reset arriving at the edge that would complete a read grant
        set_req(0, 1'b1, 1'b0, 16'h0005, 16'h0, 1'b0);
        @(negedge clk);
        check("rmr_m0_gnt", 16'(m0_gnt), 16'd1);
        #1 rstn = 1'b0;
        #1 model_cycle();
        next_cycle();
        set_req(1, 1'b1, 1'b0, 16'h0006, 16'h0, 1'b0);
        @(negedge clk); model_cycle();
        check("rmr_no_rvalid", 16'({m1_rvalid, m0_rvalid}), 16'd0);
        next_cycle();
        rstn = 1'b1;
        @(negedge clk); model_cycle();
        check("rmr_m0_first", 16'(m0_gnt), 16'd1);
        check("rmr_m1_wait", 16'(m1_gnt), 16'd0);

        // randomized traffic with occasional resets
        for (int c = 0; c < 4000; c++) begin
            next_cycle();
            rstn = ($urandom_range(0, 199) != 0);
            for (int m = 0; m < 2; m++)
                if (!rq[m] || gmask[m]) new_req(m);
            @(negedge clk); model_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/myrisc16_mem_arb.md
# myrisc16_mem_arb

Two-port round-robin arbiter that shares the single 16-bit-word synchronous memory between the myrisc16 core (port 0) and the program loader / debug port (port 1). It issues at most one memory access per cycle, returns read data one cycle after grant, and optionally supports locked back-to-back sequences with a bounded lock length so neither master starves.

## Interface
- AW, 16, memory word-address width
- DW, 16, data width
- LOCK_MAX, 8, max consecutive locked grants to one master while the other waits (1..255)

- clk  in  1  clock; all state on rising edge
- rstn  in  1  reset, synchronous, active-low
- mN_req  in  1  access request, N=0,1; held until granted
- mN_we  in  1  1=write, 0=read; stable while req
- mN_addr  in  AW  word address; stable while req
- mN_wdata  in  DW  write data; stable while req
- mN_lock  in  1  request to keep ownership after this grant (only with MYRISC16_ARB_LOCK_EN)
- mN_gnt  out  1  combinational; access issued this cycle
- mN_rvalid  out  1  registered; read data valid
- mN_rdata  out  DW  read data (= mem_rdata), meaningful only when mN_rvalid
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid one cycle after mem_en with mem_we=0

## Operation
- State: last (1 bit, last granted master), owner (1 bit) + locked (1 bit), lock_cnt (8 bit), rd_pend (1 bit), rd_id (1 bit).
- Arbitration each cycle, rstn=1:
  - locked and owner requesting, other not requesting or lock_cnt<LOCK_MAX: grant owner.
  - locked but lock_cnt==LOCK_MAX and other requesting: grant other (lock broken), clear locked.
  - not locked, one request: grant it. Both: grant !last.
  - none: no grant; mem_en=0.
- Grant drives mem_en=1, mem_we/addr/wdata muxed from winner; last<=winner.
- Lock update on grant: mN_lock=1 -> locked<=1, owner<=winner, lock_cnt<=(same owner and already locked) ? lock_cnt+1 saturating : 1. mN_lock=0 -> locked<=0, lock_cnt<=0.
- Owner drops req while locked -> locked<=0, lock_cnt<=0 same edge.
- Reads: on read grant rd_pend<=1, rd_id<=winner; next cycle mN_rvalid=1 for rd_id, rdata=mem_rdata. Writes produce no rvalid; complete at grant.
- Back-to-back reads allowed every cycle; rvalid may be continuous.
- Reset (rstn=0 on edge): last<=1 (port 0 wins first tie), locked<=0, lock_cnt<=0, rd_pend<=0. While rstn=0 gnt, mem_en forced 0. Reset mid-read: pending rvalid dropped.

## Timing
- Grant latency: 0 cycles (gnt same cycle as req if winning); read latency: 1 cycle grant->rvalid.
- Reset outputs: m0_gnt=m1_gnt=0, m0_rvalid=m1_rvalid=0, mem_en=0, mem_we=0; mem_addr/wdata don't-care.
- Throughput: 1 access/cycle; under contention without lock, strict alternation.
- Max wait for a requester: 1 cycle unlocked, LOCK_MAX cycles locked.
- Exactly one of m0_gnt, m1_gnt high, or neither; mem_en = m0_gnt|m1_gnt.

## Configuration
- MYRISC16_ARB_LOCK_EN defined: mN_lock ports exist, lock logic and LOCK_MAX active.
- Undefined: mN_lock ports absent, locked/lock_cnt not implemented; pure round-robin; LOCK_MAX ignored.

## Test plan
- Reset: rstn=0 with both req=1 -> gnt=0, mem_en=0, rvalid=0; first cycle after release both req -> m0_gnt=1.
- Single read: m1 reads addr 0x0040 holding 0xBEEF -> m1_gnt same cycle, m1_rvalid=1, m1_rdata=0xBEEF next cycle, m0_rvalid=0.
- Contention: both continuously request reads 0x0001/0x0002 -> grants alternate 0,1,0,1; rvalid follows with 1-cycle lag to matching port.
- Write then read: m0 writes 0x1234 to 0x0010, m1 reads 0x0010 next cycle -> m1_rdata=0x1234.
- Lock (LOCK_EN, LOCK_MAX=3): m1 req+lock continuously, m0 req -> m1 granted 3 cycles, m0 granted 4th cycle, then m1 again.
- Reset mid-read: read granted, rstn=0 next edge -> no rvalid; after release arbitration restarts with m0 priority.
